alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of the illegal-instruction counter.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high. Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, fetch stage presents an instruction.
- in_ready, out, 1, block accepts the instruction this cycle.
- in_instr, in, 32, RV32I instruction word.
- in_pc, in, 32, instruction address.
- flush, in, 1, discard held and incoming instruction.
- ex_ready, in, 1, EX stage accepts the output this cycle.
- ex_valid, out, 1, output register holds a valid decode.
- ex_alu_ctr, out, 4, ALU operation code.
- ex_a_sel, out, 2, ALU I1 source: 00 rs1, 01 pc, 10 zero.
- ex_b_sel, out, 1, ALU I2 source: 0 rs2, 1 imm.
- ex_imm, out, 32, sign-extended immediate.
- ex_rd / ex_rs1 / ex_rs2, out, 5 each, register indices.
- ex_reg_write / ex_mem_read / ex_mem_write / ex_branch, out, 1 each, control bits.
- ex_pc, out, 32, registered in_pc.
- ex_illegal, out, 1, decode failed.
- illegal_cnt, out, CNT_W, count of illegal instructions.

Function
REQ-003 The block SHALL drive ex_alu_ctr with these codes: AND 0000, OR 0001, ADD 0010, SUB 0011, SLT 0100, SLL 0101, SRL 0110, XOR 0111, JAL 1010, JALR 1011.
REQ-004 The block SHALL decode opcode 0110011 (R-type) by funct3/funct7:
- 000 with funct7 0000000 is ADD; 000 with funct7 0100000 is SUB.
- 001/0000000 is SLL; 010/0000000 is SLT; 100/0000000 is XOR; 101/0000000 is SRL; 110/0000000 is OR; 111/0000000 is AND.
- All other funct3/funct7 combinations are illegal.
REQ-005 The block SHALL decode opcode 0010011 as ADDI/SLTI/XORI/ORI/ANDI (funct3 000/010/100/110/111), and as SLLI/SRLI (funct3 001/101 with funct7 0000000); b_sel=1; all other funct3/funct7 combinations are illegal.
REQ-006 The block SHALL decode the remaining opcodes as follows:
- Load 0000011 and store 0100011: ADD, b_sel=1, mem_read or mem_write set.
- Branch 1100011 with funct3 000/001: SUB, b_sel=0, branch=1.
- LUI 0110111: ADD, a_sel=10, b_sel=1.
- AUIPC 0010111: ADD, a_sel=01, b_sel=1.
- JAL 1101111: 1010, a_sel=01, b_sel=1.
- JALR 1100111 with funct3 000: 1011, a_sel=00, b_sel=1.
REQ-007 The block SHALL form ex_imm in RV32I I/S/B/U/J format, sign-extended from bit 31; B and J immediates have bit 0 = 0; ex_imm SHALL be 0 for R-type.
REQ-008 Any opcode not listed SHALL be illegal. An illegal instruction SHALL set ex_illegal=1, ex_alu_ctr=0000, and all control bits 0.
REQ-009 ex_reg_write SHALL be 1 for R, I-ALU, load, LUI, AUIPC, JAL and JALR, and SHALL be forced to 0 when rd==0.
REQ-010 The block SHALL drive in_ready = flush | !ex_valid | ex_ready (combinational).
REQ-011 A transfer SHALL occur when in_valid & in_ready & !flush; the decoded fields SHALL be registered and ex_valid SHALL be 1 on the next edge (latency 1).
REQ-012 The output register SHALL hold all ex_* values stable while ex_valid & !ex_ready.
REQ-013 When ex_valid & ex_ready and no new transfer occurs, ex_valid SHALL be 0 on the next edge.
REQ-014 flush SHALL take priority over everything else: ex_valid goes to 0 on the next edge, and any in_valid instruction in the same cycle is dropped.
REQ-015 illegal_cnt SHALL increment by 1 on each transfer with an illegal decode, SHALL saturate at all-ones, and SHALL NOT count dropped (flushed) instructions.

Reset
REQ-016 While rst=1 the block SHALL hold ex_valid=0, illegal_cnt=0, and all other ex_* outputs at 0, regardless of clk.
REQ-017 After rst deasserts, in_ready SHALL be 1 and the first transfer SHALL occur on the first rising clk edge with in_valid=1.
REQ-018 Reset asserted mid-stall SHALL discard the held instruction immediately.

Verification
REQ-019 in_instr=0x002081B3 (ADD x3,x1,x2), ex_ready=1 -> next cycle: ex_valid=1, alu_ctr=0010, rd=3, rs1=1, rs2=2, b_sel=0, reg_write=1.
REQ-020 in_instr=0x407302B3 (SUB x5,x6,x7) -> alu_ctr=0011, rd=5; then 0xFFF00093 (ADDI x1,x0,-1) -> alu_ctr=0010, imm=0xFFFFFFFF, b_sel=1.
REQ-021 in_instr=0x008000EF (JAL x1,+8), in_pc=0x100 -> alu_ctr=1010, a_sel=01, imm=0x00000008, ex_pc=0x100, reg_write=1.
REQ-022 ex_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, ex_* unchanged for those cycles; ex_ready=1 -> the next instruction appears one cycle later.
REQ-023 Send 0xFFFFFFFF twice, the second with flush=1 -> ex_illegal=1 once and illegal_cnt=1; preload the counter near saturation -> illegal_cnt stays at 0xFFFF.
REQ-024 Assert rst while ex_valid=1 and ex_ready=0 -> ex_valid=0 and illegal_cnt=0 before the next clk edge.

Source files
------------

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns a fetched instruction into ALU/control fields
// behind a one-entry valid/ready output register, with an illegal counter.
module alu_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_ctr,
  output logic [1:0]       ex_a_sel,
  output logic             ex_b_sel,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic [31:0]      ex_pc,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;

  localparam logic [3:0] A_AND  = 4'b0000;
  localparam logic [3:0] A_OR   = 4'b0001;
  localparam logic [3:0] A_ADD  = 4'b0010;
  localparam logic [3:0] A_SUB  = 4'b0011;
  localparam logic [3:0] A_SLT  = 4'b0100;
  localparam logic [3:0] A_SLL  = 4'b0101;
  localparam logic [3:0] A_SRL  = 4'b0110;
  localparam logic [3:0] A_XOR  = 4'b0111;
  localparam logic [3:0] A_JAL  = 4'b1010;
  localparam logic [3:0] A_JALR = 4'b1011;

  typedef struct packed {
    logic [3:0]  alu;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
  } dec_t;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [3:0]  f3_alu;
  logic        bad;
  dec_t        dec_d;
  dec_t        dec_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic        xfer;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25],
                  in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31],
                  in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // funct3 selects the same operation for R-type and I-type ALU ops
  always_comb begin
    f3_alu = A_ADD;
    unique case (f3)
      3'b000:  f3_alu = A_ADD;
      3'b001:  f3_alu = A_SLL;
      3'b010:  f3_alu = A_SLT;
      3'b100:  f3_alu = A_XOR;
      3'b101:  f3_alu = A_SRL;
      3'b110:  f3_alu = A_OR;
      3'b111:  f3_alu = A_AND;
      default: f3_alu = A_ADD;
    endcase
  end

  always_comb begin
    dec_d     = '0;
    dec_d.rd  = in_instr[11:7];
    dec_d.rs1 = in_instr[19:15];
    dec_d.rs2 = in_instr[24:20];
    bad       = 1'b0;
    unique case (1'b1)
      (op == OP_R): begin
        dec_d.rw  = 1'b1;
        if (f7 == 7'h00 && f3 != 3'b011)
          dec_d.alu = f3_alu;
        else if (f7 == 7'h20 && f3 == 3'b000)
          dec_d.alu = A_SUB;
        else
          bad = 1'b1;
      end
      (op == OP_I): begin
        dec_d.alu   = f3_alu;
        dec_d.b_sel = 1'b1;
        dec_d.rw    = 1'b1;
        dec_d.imm   = imm_i;
        if (f3 == 3'b011)
          bad = 1'b1;
        else if ((f3 == 3'b001 || f3 == 3'b101)
                 && f7 != 7'h00)
          bad = 1'b1;
      end
      (op == OP_LD): begin
        dec_d.alu   = A_ADD;
        dec_d.b_sel = 1'b1;
        dec_d.mr    = 1'b1;
        dec_d.rw    = 1'b1;
        dec_d.imm   = imm_i;
      end
      (op == OP_ST): begin
        dec_d.alu   = A_ADD;
        dec_d.b_sel = 1'b1;
        dec_d.mw    = 1'b1;
        dec_d.imm   = imm_s;
      end
      (op == OP_BR): begin
        dec_d.alu = A_SUB;
        dec_d.br  = 1'b1;
        dec_d.imm = imm_b;
        bad       = f3[2] | f3[1];
      end
      (op == OP_LUI): begin
        dec_d.alu   = A_ADD;
        dec_d.a_sel = 2'b10;
        dec_d.b_sel = 1'b1;
        dec_d.rw    = 1'b1;
        dec_d.imm   = imm_u;
      end
      (op == OP_AUI): begin
        dec_d.alu   = A_ADD;
        dec_d.a_sel = 2'b01;
        dec_d.b_sel = 1'b1;
        dec_d.rw    = 1'b1;
        dec_d.imm   = imm_u;
      end
      (op == OP_JAL): begin
        dec_d.alu   = A_JAL;
        dec_d.a_sel = 2'b01;
        dec_d.b_sel = 1'b1;
        dec_d.rw    = 1'b1;
        dec_d.imm   = imm_j;
      end
      (op == OP_JR): begin
        dec_d.alu   = A_JALR;
        dec_d.b_sel = 1'b1;
        dec_d.rw    = 1'b1;
        dec_d.imm   = imm_i;
        bad         = (f3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
    // illegal decodes keep register indices but drop all control
    if (bad) begin
      dec_d     = '0;
      dec_d.rd  = in_instr[11:7];
      dec_d.rs1 = in_instr[19:15];
      dec_d.rs2 = in_instr[24:20];
      dec_d.ill = 1'b1;
    end
    if (dec_d.rd == 5'd0)
      dec_d.rw = 1'b0;
  end

  assign in_ready = flush | ~valid_q | ex_ready;
  assign xfer     = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      dec_q   <= dec_d;
      pc_q    <= in_pc;
      if (dec_d.ill && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + CNT_W'(1);
    end else if (ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_alu_ctr   = dec_q.alu;
  assign ex_a_sel     = dec_q.a_sel;
  assign ex_b_sel     = dec_q.b_sel;
  assign ex_imm       = dec_q.imm;
  assign ex_rd        = dec_q.rd;
  assign ex_rs1       = dec_q.rs1;
  assign ex_rs2       = dec_q.rs2;
  assign ex_reg_write = dec_q.rw;
  assign ex_mem_read  = dec_q.mr;
  assign ex_mem_write = dec_q.mw;
  assign ex_branch    = dec_q.br;
  assign ex_illegal   = dec_q.ill;
  assign ex_pc        = pc_q;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: random and directed RV32I
// traffic against a behavioural decode model, plus a narrow-counter copy.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        ex_ready;

  logic        in_ready, ex_valid;
  logic [3:0]  ex_alu_ctr;
  logic [1:0]  ex_a_sel;
  logic        ex_b_sel;
  logic [31:0] ex_imm, ex_pc;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_illegal;
  logic [15:0] illegal_cnt;

  logic        s_in_ready, s_ex_valid;
  logic [3:0]  s_ex_alu_ctr;
  logic [1:0]  s_ex_a_sel;
  logic        s_ex_b_sel;
  logic [31:0] s_ex_imm, s_ex_pc;
  logic [4:0]  s_ex_rd, s_ex_rs1, s_ex_rs2;
  logic        s_ex_reg_write, s_ex_mem_read, s_ex_mem_write;
  logic        s_ex_branch, s_ex_illegal;
  logic [2:0]  s_illegal_cnt;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_alu_ctr(ex_alu_ctr),
    .ex_a_sel(ex_a_sel), .ex_b_sel(ex_b_sel),
    .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_pc(ex_pc),
    .ex_illegal(ex_illegal),
    .illegal_cnt(illegal_cnt)
  );

  alu_decode_stage #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .ex_ready(ex_ready),
    .ex_valid(s_ex_valid), .ex_alu_ctr(s_ex_alu_ctr),
    .ex_a_sel(s_ex_a_sel), .ex_b_sel(s_ex_b_sel),
    .ex_imm(s_ex_imm), .ex_rd(s_ex_rd),
    .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2),
    .ex_reg_write(s_ex_reg_write),
    .ex_mem_read(s_ex_mem_read),
    .ex_mem_write(s_ex_mem_write),
    .ex_branch(s_ex_branch), .ex_pc(s_ex_pc),
    .ex_illegal(s_ex_illegal),
    .illegal_cnt(s_illegal_cnt)
  );

  typedef struct packed {
    logic [3:0]  alu;
    logic [1:0]  a;
    logic        b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t g_main, g_small;
  assign g_main = {ex_alu_ctr, ex_a_sel, ex_b_sel, ex_imm,
                   ex_rd, ex_rs1, ex_rs2, ex_reg_write,
                   ex_mem_read, ex_mem_write, ex_branch,
                   ex_illegal, ex_pc};
  assign g_small = {s_ex_alu_ctr, s_ex_a_sel, s_ex_b_sel,
                    s_ex_imm, s_ex_rd, s_ex_rs1, s_ex_rs2,
                    s_ex_reg_write, s_ex_mem_read,
                    s_ex_mem_write, s_ex_branch,
                    s_ex_illegal, s_ex_pc};

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cnt_m = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name,
                     input logic [95:0] act,
                     input logic [95:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               name, act, want, $time);
    end
  endtask

  // Decode rules written straight from the instruction-set tables.
  function automatic exp_t model(input logic [31:0] i,
                                 input logic [31:0] pc);
    exp_t e;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    logic signed [31:0] s = i;
    logic [31:0] immi, imms, immb, immu, immj;
    logic [3:0] by_f3 [8] = '{4'd2, 4'd5, 4'd4, 4'd0,
                              4'd7, 4'd6, 4'd1, 4'd0};
    bit ok = 1'b1;
    immi = 32'(s >>> 20);
    imms = (32'(s >>> 20) & ~32'h1f) | 32'(i[11:7]);
    immb = (32'(s >>> 19) & 32'hFFFF_F000)
         | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
         | (32'(i[11:8]) << 1);
    immu = i & 32'hFFFF_F000;
    immj = (32'(s >>> 11) & 32'hFFF0_0000)
         | (32'(i[19:12]) << 12) | (32'(i[20]) << 11)
         | (32'(i[30:21]) << 1);
    e = '0;
    e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    e.pc = pc;
    case (op)
      7'h33: begin
        e.rw = 1;
        if (f7 == 0 && f3 != 3) e.alu = by_f3[f3];
        else if (f7 == 7'h20 && f3 == 0) e.alu = 4'd3;
        else ok = 0;
      end
      7'h13: begin
        e.b = 1; e.rw = 1; e.imm = immi;
        if (f3 == 3 || ((f3 == 1 || f3 == 5) && f7 != 0))
          ok = 0;
        else e.alu = by_f3[f3];
      end
      7'h03: begin
        e.alu = 2; e.b = 1; e.mr = 1; e.rw = 1; e.imm = immi;
      end
      7'h23: begin
        e.alu = 2; e.b = 1; e.mw = 1; e.imm = imms;
      end
      7'h63: begin
        if (f3 < 2) begin e.alu = 3; e.br = 1; e.imm = immb; end
        else ok = 0;
      end
      7'h37: begin
        e.alu = 2; e.a = 2; e.b = 1; e.rw = 1; e.imm = immu;
      end
      7'h17: begin
        e.alu = 2; e.a = 1; e.b = 1; e.rw = 1; e.imm = immu;
      end
      7'h6F: begin
        e.alu = 10; e.a = 1; e.b = 1; e.rw = 1; e.imm = immj;
      end
      7'h67: begin
        if (f3 == 0) begin
          e.alu = 11; e.b = 1; e.rw = 1; e.imm = immi;
        end else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      e.alu = 0; e.a = 0; e.b = 0; e.imm = 0;
      e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.ill = 1;
    end
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h67};
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 7) != 0)
      r[6:0] = ops[$urandom_range(0, 8)];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 9) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  // Monitor: compares whatever the output register presents.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("in_ready", 96'(in_ready),
          96'(flush || q.size() == 0 || ex_ready));
      chk("ex_valid", 96'(ex_valid), 96'(q.size() != 0));
      chk("s_ex_valid", 96'(s_ex_valid), 96'(q.size() != 0));
      if (q.size() != 0 && ex_valid) begin
        chk("fields", 96'(g_main), 96'(q[0]));
        chk("s_fields", 96'(g_small), 96'(q[0]));
      end
      chk("illegal_cnt", 96'(illegal_cnt),
          96'(cnt_m > 65535 ? 65535 : cnt_m));
      chk("s_illegal_cnt", 96'(s_illegal_cnt),
          96'(cnt_m > 7 ? 7 : cnt_m));
      if (q.size() != 0 && (ex_ready || flush))
        void'(q.pop_front());
    end
  end

  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic fl,
                       input logic rdy);
    exp_t e;
    in_valid = v; in_instr = ins; in_pc = pc;
    flush = fl; ex_ready = rdy;
    @(negedge clk);
    #1;
    if (v && !fl && q.size() == 0) begin
      e = model(ins, pc);
      q.push_back(e);
      if (e.ill) cnt_m++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0;
    flush = 0; ex_ready = 0;
    #2;
    chk("rst_valid", 96'(ex_valid), 96'(0));
    chk("rst_cnt", 96'(illegal_cnt), 96'(0));
    chk("rst_fields", 96'(g_main), 96'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 96'(in_ready), 96'(1));
    mon_en = 1'b1;

    cycle(1, 32'h002081B3, 32'h0, 0, 1);
    cycle(1, 32'h407302B3, 32'h4, 0, 1);
    cycle(1, 32'hFFF00093, 32'h8, 0, 1);
    cycle(1, 32'h008000EF, 32'h100, 0, 1);
    cycle(1, 32'h00A00513, 32'h200, 0, 1);
    repeat (3) cycle(1, 32'h00B00593, 32'h204, 0, 0);
    cycle(1, 32'h00B00593, 32'h204, 0, 1);
    cycle(0, 32'h0, 32'h0, 0, 1);
    cycle(1, 32'hFFFFFFFF, 32'h300, 0, 1);
    cycle(1, 32'hFFFFFFFF, 32'h304, 1, 1);
    cycle(0, 32'h0, 32'h0, 0, 1);

    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 3) != 0, rnd_instr(),
            $urandom, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0);

    cycle(1, 32'hFFFFFFFF, 32'h400, 0, 1);
    cycle(1, 32'h00100093, 32'h404, 0, 0);
    cycle(1, 32'h00100093, 32'h404, 0, 0);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midstall_rst_valid", 96'(ex_valid), 96'(0));
    chk("midstall_rst_cnt", 96'(illegal_cnt), 96'(0));
    chk("midstall_rst_scnt", 96'(s_illegal_cnt), 96'(0));
    q.delete();
    cnt_m = 0;
    in_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    mon_en = 1'b1;
    cycle(1, 32'h002081B3, 32'h500, 0, 1);
    cycle(0, 32'h0, 32'h0, 0, 1);
    cycle(0, 32'h0, 32'h0, 0, 1);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
